// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared state type and byte-lane width for the single-port RAM.
// Revision : 1.0 - initial parameterised release
// ============================================================================
package ram_pkg;

    localparam int RAM_BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_clr_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram_clr_seq
// Purpose  : Sweep sequencer that writes every word after reset or on request.
// Revision : 1.0 - initial parameterised release
// ============================================================================
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready    = (state_q == ST_RUN);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ram_sp_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_param
// Purpose  : Parameterised single-port RAM with byte enables and clear sweep.
//            RAM_SP_OUTREG_EN adds a second output register stage.
// Revision : 1.0 - initial parameterised release
// ============================================================================
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 3,
    parameter int                DEPTH   = 8,
    parameter logic [DATA_W-1:0] CLR_VAL = '0,
    parameter int                BE_W    = DATA_W / RAM_BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              we_n,
    input  logic [ADDR_W-1:0] addm,
    input  logic [DATA_W-1:0] din,
    input  logic [BE_W-1:0]   be,
    input  logic              clr_req,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              ready,
    output logic              oor
);

    // Index only as wide as the array needs; out-of-range addresses are masked by in_range.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              access, rd, in_range;
    logic [IDX_W-1:0]  idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              oor_q, oor_d;

    ram_clr_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign in_range = ({1'b0, addm} < (ADDR_W + 1)'(DEPTH));
    assign idx      = addm[IDX_W-1:0];
    assign access   = ready && !cs_n;
    assign rd       = access && we_n;

    // The sweep owns the single write port while it runs; user writes merge by lane.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_wdata = mem[idx];
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_idx   = clr_addr[IDX_W-1:0];
            mem_wdata = CLR_VAL;
        end else if (access && !we_n && in_range) begin
            mem_we = 1'b1;
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem_wdata[i*RAM_BYTE_W +: RAM_BYTE_W] = din[i*RAM_BYTE_W +: RAM_BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = rd;
        oor_d      = access && !in_range;
        if (rd) begin
            dout_d = in_range ? mem[idx] : CLR_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            oor_q      <= oor_d;
        end
    end

`ifdef RAM_SP_OUTREG_EN
    logic [DATA_W-1:0] dout_p2_q;
    logic              dout_vld_p2_q;
    logic              oor_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p2_q     <= '0;
            dout_vld_p2_q <= 1'b0;
            oor_p2_q      <= 1'b0;
        end else begin
            dout_p2_q     <= dout_q;
            dout_vld_p2_q <= dout_vld_q;
            oor_p2_q      <= oor_q;
        end
    end

    assign dout     = dout_p2_q;
    assign dout_vld = dout_vld_p2_q;
    assign oor      = oor_p2_q;
`else
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign oor      = oor_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_param.sv
`default_nettype none
// Bench for ram_sp_param: 16-bit words, 6 of 8 addresses populated, non-zero clear value.
module tb_ram_sp_param;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 3;
    localparam int          DEPTH  = 6;
    localparam logic [15:0] CLR    = 16'h5A3C;
`ifdef RAM_SP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        we_n = 1'b1;
    logic [2:0]  addm = '0;
    logic [15:0] din = '0;
    logic [1:0]  be = '0;
    logic        clr_req = 1'b0;
    logic [15:0] dout;
    logic        dout_vld, ready, oor;

    int checks = 0;
    int errors = 0;

    // Reference: word array, cycles of clearing left, and the output pipeline stages.
    logic [15:0] m_mem [8];
    int          clear_left;
    logic [15:0] s1_dout, s2_dout;
    logic        s1_vld, s2_vld, s1_oor, s2_oor;

    ram_sp_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .CLR_VAL (CLR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .we_n     (we_n),
        .addm     (addm),
        .din      (din),
        .be       (be),
        .clr_req  (clr_req),
        .dout     (dout),
        .dout_vld (dout_vld),
        .ready    (ready),
        .oor      (oor)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] e_dout(); return (LAT == 2) ? s2_dout : s1_dout; endfunction
    function automatic logic e_vld(); return (LAT == 2) ? s2_vld : s1_vld; endfunction
    function automatic logic e_oor(); return (LAT == 2) ? s2_oor : s1_oor; endfunction
    function automatic logic e_rdy(); return clear_left == 0; endfunction

    task automatic model_reset();
        clear_left = DEPTH;
        s1_dout = '0; s2_dout = '0;
        s1_vld = 1'b0; s2_vld = 1'b0;
        s1_oor = 1'b0; s2_oor = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] nd;
        logic        nv, no;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s2_dout = s1_dout; s2_vld = s1_vld; s2_oor = s1_oor;
        nd = s1_dout; nv = 1'b0; no = 1'b0;
        if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = CLR;
            clear_left--;
        end else begin
            if (!cs_n) begin
                if (int'(addm) >= DEPTH) begin
                    no = 1'b1;
                    if (we_n) begin nd = CLR; nv = 1'b1; end
                end else if (we_n) begin
                    nd = m_mem[addm]; nv = 1'b1;
                end else begin
                    for (int b = 0; b < 2; b++)
                        if (be[b]) m_mem[addm][8*b +: 8] = din[8*b +: 8];
                end
            end
            if (clr_req) clear_left = DEPTH;
        end
        s1_dout = nd; s1_vld = nv; s1_oor = no;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [2:0] a,
                         input logic [15:0] d, input logic [1:0] b);
        cs_n = c; we_n = w; addm = a; din = d; be = b;
    endtask

    task automatic test_reset();
        int n;
        drive(1'b0, 1'b0, 3'd1, 16'hFFFF, 2'b11);
        repeat (2) step();
        checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0000", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", dout_vld); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (oor !== 1'b0) begin errors++; $display("FAIL reset_oor got %b want 0", oor); end
        rst_n = 1'b1;
        n = 0;
        // Writes issued during the sweep must be ignored.
        while (ready !== 1'b1 && n < 50) begin
            drive(1'b0, $urandom_range(0, 1), 3'($urandom), 16'($urandom), 2'b11);
            step();
            n++;
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL sweep_cycle n=%0d got %h %b %b %b want %h %b %b %b",
                         n, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
        end
        checks++; if (n !== DEPTH) begin errors++; $display("FAIL ready_latency got %0d want %0d", n, DEPTH); end
        drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
    endtask

    task automatic test_clear_contents();
        int vld_cnt = 0, oor_cnt = 0;
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) drive(1'b0, 1'b1, 3'(i), 16'($urandom), 2'($urandom));
            else       drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
            step();
            if (dout_vld === 1'b1) vld_cnt++;
            if (oor === 1'b1) oor_cnt++;
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL clear_read i=%0d got %h %b %b %b want %h %b %b %b",
                         i, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
            if (i >= LAT && dout_vld === 1'b1) begin
                checks++;
                if (dout !== CLR) begin errors++; $display("FAIL clear_value i=%0d got %h want %h", i, dout, CLR); end
            end
        end
        checks++; if (vld_cnt !== 8) begin errors++; $display("FAIL clear_vld_count got %0d want 8", vld_cnt); end
        checks++; if (oor_cnt !== 2) begin errors++; $display("FAIL clear_oor_count got %0d want 2", oor_cnt); end
    endtask

    task automatic test_write_read();
        // Writes 1..5, a write-then-read pair on addr 4, then reads 5 down to 1.
        for (int i = 0; i < 12 + LAT; i++) begin
            if (i < 5)       drive(1'b0, 1'b0, 3'(i + 1), 16'(i + 1) | 16'($urandom) & 16'hFF00, 2'b11);
            else if (i == 5) drive(1'b0, 1'b0, 3'd4, 16'($urandom), 2'b11);
            else if (i == 6) drive(1'b0, 1'b1, 3'd4, 16'h0, 2'b00);
            else if (i < 12) drive(1'b0, 1'b1, 3'(12 - i), 16'h0, 2'($urandom));
            else             drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
            step();
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL write_read i=%0d got %h %b %b %b want %h %b %b %b",
                         i, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
        end
    endtask

    task automatic test_byte_enable();
        drive(1'b0, 1'b0, 3'd2, 16'hAAAA, 2'b11); step();
        drive(1'b0, 1'b0, 3'd2, 16'h5555, 2'b01); step();
        drive(1'b0, 1'b0, 3'd2, 16'h1234, 2'b00); step();
        drive(1'b0, 1'b1, 3'd2, 16'h0000, 2'b10); step();
        drive(1'b1, 1'b1, 3'd0, 16'h0000, 2'b00);
        repeat (LAT - 1) step();
        checks++;
        if (dout !== 16'hAA55 || dout_vld !== 1'b1) begin
            errors++;
            $display("FAIL byte_enable got %h vld %b want aa55 vld 1", dout, dout_vld);
        end
        step();
        checks++;
        if (dout !== 16'hAA55 || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL dout_hold got %h vld %b want aa55 vld 0", dout, dout_vld);
        end
    endtask

    task automatic test_cs_idle();
        for (int i = 0; i < 6 + 6 + LAT; i++) begin
            if (i < 6)       drive(1'b1, 1'b0, 3'($urandom), 16'($urandom), 2'b11);
            else if (i < 12) drive(1'b0, 1'b1, 3'(i - 6), 16'h0, 2'b00);
            else             drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
            step();
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL cs_idle i=%0d got %h %b %b %b want %h %b %b %b",
                         i, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
        end
    endtask

    task automatic test_clr_req();
        logic [15:0] got;
        int n;
        got = 16'hxxxx;
        drive(1'b0, 1'b0, 3'd3, 16'h0003, 2'b11); step();
        drive(1'b0, 1'b1, 3'd3, 16'h0000, 2'b00); clr_req = 1'b1; step();
        clr_req = 1'b0;
        if (dout_vld === 1'b1) got = dout;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            drive(1'b0, $urandom_range(0, 1), 3'($urandom), 16'($urandom), 2'b11);
            step();
            n++;
            if (dout_vld === 1'b1 && n < LAT) got = dout;
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL clr_sweep n=%0d got %h %b %b %b want %h %b %b %b",
                         n, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
        end
        checks++; if (got !== 16'h0003) begin errors++; $display("FAIL clr_same_cycle_read got %h want 0003", got); end
        checks++; if (n !== DEPTH) begin errors++; $display("FAIL clr_ready_latency got %0d want %0d", n, DEPTH); end
        drive(1'b0, 1'b1, 3'd3, 16'h0, 2'b00); step();
        drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
        repeat (LAT - 1) step();
        checks++;
        if (dout !== CLR || dout_vld !== 1'b1) begin
            errors++;
            $display("FAIL clr_readback got %h vld %b want %h vld 1", dout, dout_vld, CLR);
        end
    endtask

    task automatic test_oor();
        int oor_cnt = 0;
        for (int i = 0; i < 2 + LAT; i++) begin
            if (i == 0)      drive(1'b0, 1'b0, 3'd7, 16'($urandom), 2'b11);
            else if (i == 1) drive(1'b0, 1'b1, 3'd7, 16'h0, 2'b00);
            else             drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
            step();
            if (oor === 1'b1) oor_cnt++;
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL oor i=%0d got %h %b %b %b want %h %b %b %b",
                         i, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
        end
        checks++; if (oor_cnt !== 2) begin errors++; $display("FAIL oor_count got %0d want 2", oor_cnt); end
        checks++; if (dout !== CLR) begin errors++; $display("FAIL oor_read got %h want %h", dout, CLR); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom), 16'($urandom), 2'($urandom));
            clr_req = ($urandom_range(0, 59) == 0);
            step();
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL random i=%0d got %h %b %b %b want %h %b %b %b",
                         i, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
        end
        clr_req = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
        while (!e_rdy()) step();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        drive(1'b0, 1'b1, 3'd1, 16'h0, 2'b00);
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({dout, dout_vld, oor, ready} !== {16'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %h %b %b %b want 0000 0 0 0", dout, dout_vld, oor, ready);
        end
        repeat (2) step();
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin step(); n++; end
        checks++; if (n !== DEPTH) begin errors++; $display("FAIL restart_latency got %0d want %0d", n, DEPTH); end
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) drive(1'b0, 1'b1, 3'(i), 16'h0, 2'b00);
            else       drive(1'b1, 1'b1, 3'd0, 16'h0, 2'b00);
            step();
            checks++;
            if ({dout, dout_vld, oor, ready} !== {e_dout(), e_vld(), e_oor(), e_rdy()}) begin
                errors++;
                $display("FAIL restart_read i=%0d got %h %b %b %b want %h %b %b %b",
                         i, dout, dout_vld, oor, ready, e_dout(), e_vld(), e_oor(), e_rdy());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_mem[i] = 16'hxxxx;
        model_reset();
        test_reset();
        test_clear_contents();
        test_write_read();
        test_byte_enable();
        test_cs_idle();
        test_clr_req();
        test_oor();
        test_random();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
